cond_branch_unit: RTL and testbench
===================================

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; reset==0 clears all state immediately, independent of clk.
REQ-003 SHALL have port: BR_REQ_ID  input  1  conditional-branch instruction present in ID this cycle.
REQ-004 SHALL have port: COND_ID  input  4  condition field of the branch in ID.
REQ-005 SHALL have port: TARGET_ID  input  32  branch target address computed in ID.
REQ-006 SHALL have port: CC_WE_EX  input  1  flag-setting instruction in EX this cycle; the flag register updates at the next edge.
REQ-007 SHALL have ports: Z_CC, N_CC, C_CC, V_CC  input  1 each  committed condition codes from the flag register.
REQ-008 SHALL have port: STALL_ID  output  1  hold the IF/ID stages this cycle (combinational).
REQ-009 SHALL have port: BR_TAKEN  output  1  registered one-cycle pulse; the branch resolved taken.
REQ-010 SHALL have port: BR_TARGET  output  32  registered target; valid while BR_TAKEN==1.
REQ-011 SHALL have port: FLUSH_IF  output  1  registered one-cycle pulse, equal to BR_TAKEN; squash the wrong-path instruction.
REQ-012 SHALL have port: TAKEN_CNT  output  16  count of taken branches.

Function
REQ-013 SHALL decode COND as follows: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-014 SHALL implement the FSM states IDLE, WAIT_CC and FLUSH.
REQ-015 In IDLE, a hazard SHALL be BR_REQ_ID & CC_WE_EX & COND_ID not in {E,F}.
REQ-016 In IDLE with a hazard: STALL_ID=1; latch COND_ID and TARGET_ID; next state WAIT_CC.
REQ-017 In IDLE with BR_REQ_ID and no hazard: evaluate COND_ID against the current CC inputs; at the edge, BR_TAKEN<=result, FLUSH_IF<=result, BR_TARGET<=TARGET_ID; next state FLUSH if taken, else IDLE.
REQ-018 In WAIT_CC: STALL_ID=1; BR_REQ_ID and COND_ID SHALL be ignored.
REQ-019 In WAIT_CC, if CC_WE_EX==1, the FSM SHALL remain in WAIT_CC.
REQ-020 In WAIT_CC, if CC_WE_EX==0: evaluate the latched condition against the current CC; register the outputs as in REQ-017; next state FLUSH if taken, else IDLE.
REQ-021 Latency SHALL be 1 cycle from request to BR_TAKEN without a hazard, and 2 cycles with a single-cycle hazard.
REQ-022 FLUSH SHALL last exactly one cycle: BR_REQ_ID is ignored (wrong-path instruction), STALL_ID=0, next state IDLE.
REQ-023 BR_TAKEN and FLUSH_IF SHALL be 0 in every cycle not directly following an evaluation edge.
REQ-024 BR_TARGET SHALL hold its last value when not updated.
REQ-025 TAKEN_CNT SHALL increment by 1 on each taken evaluation and wrap from 0xFFFF to 0x0000.
REQ-026 STALL_ID SHALL be 0 in IDLE without a hazard and in FLUSH.

Reset
REQ-027 While reset==0: state=IDLE; BR_TAKEN=0; FLUSH_IF=0; BR_TARGET=0; TAKEN_CNT=0; latched COND/TARGET=0; STALL_ID=0.
REQ-028 Reset asserted in WAIT_CC or FLUSH SHALL abandon the pending branch with no BR_TAKEN pulse after release.
REQ-029 The first evaluation SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-030 Bench SHALL cover no hazard: Z_CC=1, BR_REQ_ID=1, COND=0 (EQ), TARGET=0x100 -> next cycle BR_TAKEN=1, FLUSH_IF=1, BR_TARGET=0x100, TAKEN_CNT=1; then FLUSH state with a BR_REQ_ID ignored.
REQ-031 Bench SHALL cover hazard: BR_REQ_ID=1, COND=1 (NE), CC_WE_EX=1 -> STALL_ID=1 for 2 cycles (IDLE+WAIT_CC); the flag register updates Z=0; BR_TAKEN=1 two cycles after the request.
REQ-032 Bench SHALL cover AL/NV with CC_WE_EX=1 -> no stall; AL taken after 1 cycle; NV gives BR_TAKEN=0 and TAKEN_CNT unchanged.
REQ-033 Bench SHALL cover all 16 conditions: each combination of N, Z, C, V -> BR_TAKEN matches the REQ-013 table, including GE/LT/GT/LE with N!=V.
REQ-034 Bench SHALL cover counter wrap: preset 0xFFFF taken branches, then one more -> TAKEN_CNT=0x0000.
REQ-035 Bench SHALL cover reset during WAIT_CC: reset=0 mid-cycle asynchronously -> outputs 0 immediately; after release, no BR_TAKEN pulse and state IDLE.

Source files
------------

// File: rtl/cond_branch_unit_if.sv
// Bus between the ID stage / flag register and the conditional-branch resolver.
// The pipeline side is the master; the resolver is the slave.
interface cond_branch_unit_if;
    logic        BR_REQ_ID;
    logic [3:0]  COND_ID;
    logic [31:0] TARGET_ID;
    logic        CC_WE_EX;
    logic        Z_CC;
    logic        N_CC;
    logic        C_CC;
    logic        V_CC;
    logic        STALL_ID;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        FLUSH_IF;
    logic [15:0] TAKEN_CNT;

    modport master (
        output BR_REQ_ID, COND_ID, TARGET_ID, CC_WE_EX, Z_CC, N_CC, C_CC, V_CC,
        input  STALL_ID, BR_TAKEN, BR_TARGET, FLUSH_IF, TAKEN_CNT
    );

    modport slave (
        input  BR_REQ_ID, COND_ID, TARGET_ID, CC_WE_EX, Z_CC, N_CC, C_CC, V_CC,
        output STALL_ID, BR_TAKEN, BR_TARGET, FLUSH_IF, TAKEN_CNT
    );
endinterface

// File: rtl/cond_branch_unit.sv
// Conditional-branch resolver: evaluates the branch condition against the flags,
// stalls ID while a flag-setting instruction in EX is still in flight.
module cond_branch_unit (
    input  logic              clk,
    input  logic              reset,
    cond_branch_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_CC = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cond;
    logic [31:0] r_target;
    logic        r_br_taken;
    logic [31:0] r_br_target;
    logic [15:0] r_taken_cnt;

    logic        w_hazard;
    logic        w_eval;
    logic        w_result;
    logic [3:0]  w_cond;
    logic [31:0] w_target;

    // AL/NV never look at the flags, so a pending flag write is not a hazard for them.
    assign w_hazard = (r_state == ST_IDLE) & bus.BR_REQ_ID & bus.CC_WE_EX
                    & (bus.COND_ID[3:1] != 3'b111);

    assign w_eval = ((r_state == ST_IDLE) & bus.BR_REQ_ID & ~w_hazard)
                  | ((r_state == ST_WAIT_CC) & ~bus.CC_WE_EX);

    assign w_cond   = (r_state == ST_WAIT_CC) ? r_cond   : bus.COND_ID;
    assign w_target = (r_state == ST_WAIT_CC) ? r_target : bus.TARGET_ID;

    always_comb begin
        w_result = 1'b0;
        case (w_cond)
            4'h0: w_result = bus.Z_CC;
            4'h1: w_result = ~bus.Z_CC;
            4'h2: w_result = bus.C_CC;
            4'h3: w_result = ~bus.C_CC;
            4'h4: w_result = bus.N_CC;
            4'h5: w_result = ~bus.N_CC;
            4'h6: w_result = bus.V_CC;
            4'h7: w_result = ~bus.V_CC;
            4'h8: w_result = bus.C_CC & ~bus.Z_CC;
            4'h9: w_result = ~bus.C_CC | bus.Z_CC;
            4'hA: w_result = (bus.N_CC == bus.V_CC);
            4'hB: w_result = (bus.N_CC != bus.V_CC);
            4'hC: w_result = ~bus.Z_CC & (bus.N_CC == bus.V_CC);
            4'hD: w_result = bus.Z_CC | (bus.N_CC != bus.V_CC);
            4'hE: w_result = 1'b1;
            default: w_result = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = ST_IDLE;
        if (w_hazard)
            w_state_next = ST_WAIT_CC;
        else if ((r_state == ST_WAIT_CC) & bus.CC_WE_EX)
            w_state_next = ST_WAIT_CC;
        else if (w_eval & w_result)
            w_state_next = ST_FLUSH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cond      <= 4'h0;
            r_target    <= 32'h0;
            r_br_taken  <= 1'b0;
            r_br_target <= 32'h0;
            r_taken_cnt <= 16'h0;
        end else begin
            r_state    <= w_state_next;
            r_br_taken <= w_eval & w_result;
            if (w_hazard) begin
                r_cond   <= bus.COND_ID;
                r_target <= bus.TARGET_ID;
            end
            if (w_eval)
                r_br_target <= w_target;
            if (w_eval & w_result)
                r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    // Stall is gated by reset so it reads 0 while the unit is held in reset.
    assign bus.STALL_ID  = reset & (w_hazard | (r_state == ST_WAIT_CC));
    assign bus.BR_TAKEN  = r_br_taken;
    assign bus.FLUSH_IF  = r_br_taken;
    assign bus.BR_TARGET = r_br_target;
    assign bus.TAKEN_CNT = r_taken_cnt;
endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit: expected outputs are queued when a
// branch is driven and compared one cycle later.
module tb_cond_branch_unit;
    logic clk;
    logic reset;

    cond_branch_unit_if bus ();

    cond_branch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        taken;
        logic        flush;
        logic [31:0] target;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m_target;
    logic [15:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic cond_model(input logic [3:0] c, input logic n, input logic z,
                                        input logic cf, input logic v);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_flags(input logic [3:0] nzcv);
        {bus.N_CC, bus.Z_CC, bus.C_CC, bus.V_CC} = nzcv;
    endtask

    task automatic drive(input logic req, input logic [3:0] cond, input logic [31:0] tgt,
                         input logic we);
        bus.BR_REQ_ID = req;
        bus.COND_ID   = cond;
        bus.TARGET_ID = tgt;
        bus.CC_WE_EX  = we;
    endtask

    task automatic push_eval(input logic [3:0] cond, input logic [31:0] tgt);
        exp_t e;
        e.taken  = cond_model(cond, bus.N_CC, bus.Z_CC, bus.C_CC, bus.V_CC);
        e.flush  = e.taken;
        m_target = tgt;
        if (e.taken) m_cnt = m_cnt + 16'd1;
        e.target = m_target;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.taken  = 1'b0;
        e.flush  = 1'b0;
        e.target = m_target;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t o;
        set_flags(4'b0000);
        drive(1'b1, 4'h1, 32'hDEAD_BEEF, 1'b1);
        reset = 1'b1;
        #1 reset = 1'b0;
        #3;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT};
        vectors++;
        if (o !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", o); end
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", bus.STALL_ID); end
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT};
        vectors++;
        if (o !== '0) begin miscompares++; $display("FAIL reset_held: got %h want 0", o); end
        m_target = 32'h0;
        m_cnt    = 16'h0;
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_no_hazard();
        exp_t o, e;
        set_flags(4'b0100);
        drive(1'b1, 4'h0, 32'h100, 1'b0);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL nohaz_stall: got %b want 0", bus.STALL_ID); end
        push_eval(4'h0, 32'h100);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL nohaz_eval: got %h want %h", o, e); end
        $display("txn nohaz EQ taken=%b target=%h cnt=%h", o.taken, o.target, o.cnt);
        drive(1'b1, 4'hE, 32'h200, 1'b0);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", bus.STALL_ID); end
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL flush_ignore: got %h want %h", o, e); end
        $display("txn flush ignored req taken=%b", o.taken);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic test_hazard();
        exp_t o, e;
        set_flags(4'b0100);
        drive(1'b1, 4'h1, 32'h300, 1'b1);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b1) begin miscompares++; $display("FAIL haz_stall_idle: got %b want 1", bus.STALL_ID); end
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL haz_no_early: got %h want %h", o, e); end
        set_flags(4'b0000);
        drive(1'b1, 4'h0, 32'h999, 1'b0);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b1) begin miscompares++; $display("FAIL haz_stall_wait: got %b want 1", bus.STALL_ID); end
        push_eval(4'h1, 32'h300);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL haz_eval: got %h want %h", o, e); end
        $display("txn hazard NE taken=%b target=%h cnt=%h", o.taken, o.target, o.cnt);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL haz_flush_stall: got %b want 0", bus.STALL_ID); end
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL haz_pulse_end: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        int stalls = 0;
        set_flags(4'b0000);
        drive(1'b1, 4'h0, 32'h310, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.STALL_ID === 1'b1) stalls++;
            if (i < 2) push_idle(); else push_eval(4'h0, 32'h310);
            @(posedge clk); #1;
            o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL long_hazard_%0d: got %h want %h", i, o, e); end
            if (i == 0) drive(1'b0, 4'h0, 32'h0, 1'b1);
            if (i == 1) begin set_flags(4'b0100); drive(1'b0, 4'h0, 32'h0, 1'b0); end
        end
        vectors++;
        if (stalls !== 3) begin miscompares++; $display("FAIL long_hazard_stalls: got %0d want 3", stalls); end
        $display("txn long hazard EQ taken=%b cnt=%h", o.taken, o.cnt);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL b2b_flush: got %h want %h", o, e); end
        drive(1'b1, 4'h1, 32'h320, 1'b1);
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL b2b_wait: got %h want %h", o, e); end
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        push_eval(4'h1, 32'h320);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL b2b_not_taken: got %h want %h", o, e); end
        $display("txn hazard NE not taken target=%h", o.target);
        drive(1'b1, 4'hE, 32'h330, 1'b0);
        push_eval(4'hE, 32'h330);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL b2b_next: got %h want %h", o, e); end
        $display("txn back-to-back AL taken=%b target=%h", o.taken, o.target);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL b2b_end: got %h want %h", o, e); end
    endtask

    task automatic test_al_nv();
        exp_t o, e;
        set_flags(4'b0000);
        for (int k = 0; k < 2; k++) begin
            logic [3:0] c;
            c = (k == 0) ? 4'hE : 4'hF;
            drive(1'b1, c, 32'h400 + 32'(k) * 32'h100, 1'b1);
            #1;
            vectors++;
            if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL alnv_stall_%0d: got %b want 0", k, bus.STALL_ID); end
            push_eval(c, 32'h400 + 32'(k) * 32'h100);
            @(posedge clk); #1;
            o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL alnv_eval_%0d: got %h want %h", k, o, e); end
            $display("txn cond=%h with CC_WE_EX taken=%b cnt=%h", c, o.taken, o.cnt);
            drive(1'b0, 4'h0, 32'h0, 1'b0);
            push_idle();
            @(posedge clk); #1;
            o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL alnv_after_%0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_all_conds();
        exp_t o, e;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                set_flags(4'(f));
                drive(1'b1, 4'(c), 32'h1000 + 32'(f * 16 + c), 1'b0);
                push_eval(4'(c), 32'h1000 + 32'(f * 16 + c));
                @(posedge clk); #1;
                o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
                if (o !== e) begin miscompares++; $display("FAIL cond_%h_nzcv_%b: got %h want %h", 4'(c), 4'(f), o, e); end
                $display("txn cond=%h nzcv=%b taken=%b", 4'(c), 4'(f), o.taken);
                if (e.taken) begin
                    drive(1'b0, 4'h0, 32'h0, 1'b0);
                    push_idle();
                    @(posedge clk); #1;
                    o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
                    if (o !== e) begin miscompares++; $display("FAIL cond_flush_%h_%b: got %h want %h", 4'(c), 4'(f), o, e); end
                end
            end
        end
        drive(1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        exp_t o, e;
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        force dut.r_taken_cnt = 16'hFFFF;
        #1 release dut.r_taken_cnt;
        m_cnt = 16'hFFFF;
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL wrap_preset: got %h want %h", o, e); end
        drive(1'b1, 4'hE, 32'h600, 1'b0);
        push_eval(4'hE, 32'h600);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL wrap_to_zero: got %h want %h", o, e); end
        $display("txn wrap cnt=%h", o.cnt);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL wrap_after: got %h want %h", o, e); end
    endtask

    task automatic test_reset_wait();
        exp_t o, e;
        set_flags(4'b0100);
        drive(1'b1, 4'h1, 32'h700, 1'b1);
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL rstw_enter: got %h want %h", o, e); end
        set_flags(4'b0000);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b1) begin miscompares++; $display("FAIL rstw_stall: got %b want 1", bus.STALL_ID); end
        #2 reset = 1'b0;
        #1;
        m_target = 32'h0;
        m_cnt    = 16'h0;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; vectors++;
        if (o !== '0) begin miscompares++; $display("FAIL rstw_async: got %h want 0", o); end
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL rstw_async_stall: got %b want 0", bus.STALL_ID); end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.STALL_ID !== 1'b0) begin miscompares++; $display("FAIL rstw_idle_stall: got %b want 0", bus.STALL_ID); end
        push_idle();
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL rstw_no_pulse: got %h want %h", o, e); end
        drive(1'b1, 4'hE, 32'h800, 1'b0);
        push_eval(4'hE, 32'h800);
        @(posedge clk); #1;
        o = {bus.BR_TAKEN, bus.FLUSH_IF, bus.BR_TARGET, bus.TAKEN_CNT}; e = sb.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL rstw_idle_eval: got %h want %h", o, e); end
        $display("txn after reset in WAIT_CC taken=%b target=%h cnt=%h", o.taken, o.target, o.cnt);
        drive(1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_hazard();
        test_back_to_back();
        test_al_nv();
        test_all_conds();
        test_wrap();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
